// File: rtl/pipe_hazard_pkg.sv
// ============================================================================
// Module      : pipe_hazard_pkg
// Description : Shared types and helpers for the pipeline hazard controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package pipe_hazard_pkg;

    localparam int REG_ADDR_W = 5;

    typedef enum logic [1:0] {
        INIT     = 2'd0,
        RUN      = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    // Counters hold at all-ones instead of wrapping back to zero.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (&v) ? v : v + 32'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ld_use_check.sv
// ============================================================================
// Module      : ld_use_check
// Description : Combinational load-use hazard detect between EX load and ID.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module ld_use_check
    import pipe_hazard_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] i_id_rs1,
    input  logic [REG_ADDR_W-1:0] i_id_rs2,
    input  logic [REG_ADDR_W-1:0] i_ex_rd,
    input  logic                  i_ex_load,
    output logic                  o_hazard
);

    // x0 is hard-wired zero, so a load targeting it never creates a dependency.
    assign o_hazard = i_ex_load && (i_ex_rd != '0) &&
                      ((i_ex_rd == i_id_rs1) || (i_ex_rd == i_id_rs2));

endmodule

`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
// ============================================================================
// Module      : pipe_hazard_ctrl
// Description : Pipeline stall/flush controller with memory-wait timeout.
//               Define PIPE_HAZARD_CTRL_PERF_EN to build the perf counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_hazard_ctrl
    import pipe_hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16
)(
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic                  ex_result_src,
    input  logic                  ex_pc_src,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_ex,
    output logic                  stall_mem,
    output logic                  flush_id,
    output logic                  flush_ex,
    output logic                  flush_wb,
    output logic                  mem_timeout,
    output logic [31:0]           cnt_load_stall,
    output logic [31:0]           cnt_mem_stall,
    output logic [31:0]           cnt_flush
);

    localparam int              CNT_W       = $clog2(MEM_TIMEOUT + 1);
    localparam logic [CNT_W-1:0] C_WAIT_LAST = CNT_W'(MEM_TIMEOUT - 1);

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt;
    logic [CNT_W-1:0] w_wait_cnt_nxt;

    logic w_hazard;
    logic w_init;
    logic w_mem_stall;
    logic w_pipe_rules;
    logic w_tmo;
    logic w_branch;
    logic w_ld_stall;

    ld_use_check u_ld_use (
        .i_id_rs1  (id_rs1),
        .i_id_rs2  (id_rs2),
        .i_ex_rd   (ex_rd),
        .i_ex_load (ex_result_src),
        .o_hazard  (w_hazard)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= INIT;
            r_wait_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_init         = 1'b0;
        w_mem_stall    = 1'b0;
        w_pipe_rules   = 1'b0;
        w_tmo          = 1'b0;
        case (r_state)
            INIT: begin
                w_init      = 1'b1;
                w_state_nxt = RUN;
            end
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_mem_stall    = 1'b1;
                    w_wait_cnt_nxt = '0;
                    w_state_nxt    = MEM_WAIT;
                end else begin
                    w_pipe_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Ready is checked first so a late completion beats the timeout.
                if (dmem_ready) begin
                    w_pipe_rules = 1'b1;
                    w_state_nxt  = RUN;
                end else if (r_wait_cnt == C_WAIT_LAST) begin
                    w_tmo       = 1'b1;
                    w_state_nxt = RUN;
                end else begin
                    w_mem_stall    = 1'b1;
                    w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt = INIT;
            end
        endcase
    end

    assign w_branch   = w_pipe_rules && ex_pc_src;
    assign w_ld_stall = w_pipe_rules && !ex_pc_src && w_hazard;

    // State sits at INIT during reset; gating keeps every control low meanwhile.
    assign stall_if    = rst_n && (w_mem_stall || w_ld_stall);
    assign stall_id    = rst_n && (w_mem_stall || w_ld_stall);
    assign stall_ex    = rst_n && w_mem_stall;
    assign stall_mem   = rst_n && w_mem_stall;
    assign flush_id    = rst_n && (w_init || w_branch);
    assign flush_ex    = rst_n && (w_init || w_branch || w_ld_stall);
    assign flush_wb    = rst_n && (w_init || w_mem_stall || w_tmo);
    assign mem_timeout = rst_n && w_tmo;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic [31:0] r_cnt_load_stall;
    logic [31:0] r_cnt_mem_stall;
    logic [31:0] r_cnt_flush;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt_load_stall <= '0;
            r_cnt_mem_stall  <= '0;
            r_cnt_flush      <= '0;
        end else begin
            if (w_ld_stall)  r_cnt_load_stall <= sat_inc(r_cnt_load_stall);
            if (w_mem_stall) r_cnt_mem_stall  <= sat_inc(r_cnt_mem_stall);
            if (w_branch)    r_cnt_flush      <= sat_inc(r_cnt_flush);
        end
    end

    assign cnt_load_stall = r_cnt_load_stall;
    assign cnt_mem_stall  = r_cnt_mem_stall;
    assign cnt_flush      = r_cnt_flush;
`else
    assign cnt_load_stall = '0;
    assign cnt_mem_stall  = '0;
    assign cnt_flush      = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
// ============================================================================
// Module      : tb_pipe_hazard_ctrl
// Description : Self-checking bench for pipe_hazard_ctrl (MEM_TIMEOUT=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_hazard_ctrl;

    localparam int T = 4;
`ifdef PIPE_HAZARD_CTRL_PERF_EN
    localparam bit PERF = 1'b1;
`else
    localparam bit PERF = 1'b0;
`endif

    // Output vector order: {sif, sid, sex, smem, fid, fex, fwb, tmo}
    localparam logic [7:0] E_NONE = 8'b0000_0000;
    localparam logic [7:0] E_INIT = 8'b0000_1110;
    localparam logic [7:0] E_BR   = 8'b0000_1100;
    localparam logic [7:0] E_LU   = 8'b1100_0100;
    localparam logic [7:0] E_MEM  = 8'b1111_0010;
    localparam logic [7:0] E_TMO  = 8'b0000_0011;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic       ex_result_src = 1'b0, ex_pc_src = 1'b0, dmem_req = 1'b0, dmem_ready = 1'b0;
    logic       stall_if, stall_id, stall_ex, stall_mem;
    logic       flush_id, flush_ex, flush_wb, mem_timeout;
    logic [31:0] cnt_load_stall, cnt_mem_stall, cnt_flush;

    logic [7:0]  outs;
    logic [95:0] cnts;
    assign outs = {stall_if, stall_id, stall_ex, stall_mem, flush_id, flush_ex, flush_wb, mem_timeout};
    assign cnts = {cnt_load_stall, cnt_mem_stall, cnt_flush};

    int errors = 0;
    int checks = 0;

    // Reference model: pending-INIT flag, waiting flag, cycles waited, event counts.
    bit          m_init;
    bit          m_wait;
    int          m_waited;
    logic [31:0] m_cl, m_cm, m_cf;

    typedef struct {
        logic [4:0] rs1, rs2, rd;
        logic       ld, pc, req, rdy;
        logic [7:0] exp;
    } vec_t;
    vec_t tbl[11];

    pipe_hazard_ctrl #(.MEM_TIMEOUT(T)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .id_rs1         (id_rs1),
        .id_rs2         (id_rs2),
        .ex_rd          (ex_rd),
        .ex_result_src  (ex_result_src),
        .ex_pc_src      (ex_pc_src),
        .dmem_req       (dmem_req),
        .dmem_ready     (dmem_ready),
        .stall_if       (stall_if),
        .stall_id       (stall_id),
        .stall_ex       (stall_ex),
        .stall_mem      (stall_mem),
        .flush_id       (flush_id),
        .flush_ex       (flush_ex),
        .flush_wb       (flush_wb),
        .mem_timeout    (mem_timeout),
        .cnt_load_stall (cnt_load_stall),
        .cnt_mem_stall  (cnt_mem_stall),
        .cnt_flush      (cnt_flush)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_init   = 1'b1;
        m_wait   = 1'b0;
        m_waited = 0;
        m_cl     = '0;
        m_cm     = '0;
        m_cf     = '0;
    endtask

    task automatic model_pipe(input bit hz, output logic [7:0] exp);
        exp = E_NONE;
        if (ex_pc_src) begin
            exp = E_BR;
            m_cf++;
        end else if (hz) begin
            exp = E_LU;
            m_cl++;
        end
    endtask

    task automatic model_step(output logic [7:0] exp);
        bit hz;
        hz  = ex_result_src && (ex_rd != 0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));
        exp = E_NONE;
        if (m_init) begin
            exp    = E_INIT;
            m_init = 1'b0;
        end else if (m_wait && dmem_ready) begin
            model_pipe(hz, exp);
            m_wait = 1'b0;
        end else if (m_wait && m_waited == T - 1) begin
            exp    = E_TMO;
            m_wait = 1'b0;
        end else if (m_wait || (dmem_req && !dmem_ready)) begin
            exp = E_MEM;
            if (m_wait) m_waited++;
            else        m_waited = 0;
            m_wait = 1'b1;
            m_cm++;
        end else begin
            model_pipe(hz, exp);
        end
    endtask

    // Called at a falling edge; drives, checks mid-low-phase, returns at the next falling edge.
    task automatic step(input string name, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [4:0] rd, input logic ld, input logic pc,
                        input logic req, input logic rdy, output logic [7:0] got);
        logic [7:0]  exp;
        logic [95:0] exp_cnt;
        id_rs1 = rs1; id_rs2 = rs2; ex_rd = rd;
        ex_result_src = ld; ex_pc_src = pc; dmem_req = req; dmem_ready = rdy;
        #2;
        exp_cnt = PERF ? {m_cl, m_cm, m_cf} : 96'd0;
        model_step(exp);
        got = outs;
        check(name, {88'd0, got}, {88'd0, exp});
        check({name, "_cnt"}, cnts, exp_cnt);
        @(negedge clk);
    endtask

    // Asserts reset partway through the low phase, away from any clock edge.
    task automatic async_reset(input string name);
        #3;
        rst_n = 1'b0;
        #1;
        check({name, "_outs"}, {88'd0, outs}, 96'd0);
        check({name, "_cnts"}, cnts, 96'd0);
        model_reset();
        @(negedge clk);
        check({name, "_hold"}, {88'd0, outs}, 96'd0);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] g;

        tbl[0]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
        tbl[1]  = '{5'd5,  5'd3,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, E_LU};
        tbl[2]  = '{5'd3,  5'd5,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, E_LU};
        tbl[3]  = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b0, 1'b0, 1'b0, E_NONE};
        tbl[4]  = '{5'd7,  5'd1,  5'd7,  1'b0, 1'b0, 1'b0, 1'b0, E_NONE};
        tbl[5]  = '{5'd6,  5'd8,  5'd7,  1'b1, 1'b0, 1'b0, 1'b0, E_NONE};
        tbl[6]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b0, E_BR};
        tbl[7]  = '{5'd9,  5'd2,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, E_BR};
        tbl[8]  = '{5'd4,  5'd1,  5'd4,  1'b1, 1'b0, 1'b1, 1'b1, E_LU};
        tbl[9]  = '{5'd0,  5'd0,  5'd0,  1'b0, 1'b1, 1'b0, 1'b1, E_BR};
        tbl[10] = '{5'd1,  5'd31, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0, E_LU};

        model_reset();
        repeat (2) @(negedge clk);
        check("in_reset_outs", {88'd0, outs}, 96'd0);
        check("in_reset_cnts", cnts, 96'd0);

        // Reset release: one INIT cycle of flushes, then idle.
        rst_n = 1'b1;
        step("rel_c1", 0, 0, 0, 0, 0, 0, 0, g);
        check("rel_c1_exp", {88'd0, g}, {88'd0, E_INIT});
        step("rel_c2", 0, 0, 0, 0, 0, 0, 0, g);
        check("rel_c2_exp", {88'd0, g}, 96'd0);

        // Load-use hazard lasts one cycle.
        step("lu", 0, 5, 5, 1, 0, 0, 0, g);
        check("lu_exp", {88'd0, g}, {88'd0, E_LU});
        step("lu_after", 0, 0, 0, 0, 0, 0, 0, g);
        check("lu_after_exp", {88'd0, g}, 96'd0);
        check("lu_cnt", {64'd0, cnt_load_stall}, PERF ? 96'd1 : 96'd0);

        // Branch overrides the same hazard.
        step("br_lu", 0, 5, 5, 1, 1, 0, 0, g);
        check("br_lu_exp", {88'd0, g}, {88'd0, E_BR});

        // Memory wait: three stalled cycles, released on ready.
        step("mw_entry", 0, 0, 0, 0, 0, 1, 0, g);
        check("mw_entry_exp", {88'd0, g}, {88'd0, E_MEM});
        step("mw_w1", 5, 5, 5, 1, 1, 1, 0, g);
        check("mw_w1_exp", {88'd0, g}, {88'd0, E_MEM});
        step("mw_w2", 0, 0, 0, 0, 0, 1, 0, g);
        check("mw_w2_exp", {88'd0, g}, {88'd0, E_MEM});
        step("mw_rdy", 0, 0, 0, 0, 0, 1, 1, g);
        check("mw_rdy_exp", {88'd0, g}, 96'd0);
        check("mw_cnt", {64'd0, cnt_mem_stall}, PERF ? 96'd3 : 96'd0);

        // Timeout: entry, three stalled waits, pulse on the 4th MEM_WAIT cycle.
        step("to_entry", 0, 0, 0, 0, 0, 1, 0, g);
        for (int i = 1; i <= 3; i++) begin
            step($sformatf("to_w%0d", i), 0, 0, 0, 0, 0, 1, 0, g);
            check($sformatf("to_w%0d_exp", i), {88'd0, g}, {88'd0, E_MEM});
        end
        step("to_pulse", 0, 0, 0, 0, 0, 1, 0, g);
        check("to_pulse_exp", {88'd0, g}, {88'd0, E_TMO});
        step("to_run", 0, 2, 2, 1, 0, 0, 0, g);
        check("to_run_exp", {88'd0, g}, {88'd0, E_LU});
        check("to_cnt", {64'd0, cnt_mem_stall}, PERF ? 96'd7 : 96'd0);

        // Ready on the would-be timeout cycle wins.
        step("rw_entry", 0, 0, 0, 0, 0, 1, 0, g);
        for (int i = 1; i <= 3; i++) step($sformatf("rw_w%0d", i), 0, 0, 0, 0, 0, 1, 0, g);
        step("rw_rdy", 0, 0, 0, 0, 1, 1, 1, g);
        check("rw_rdy_exp", {88'd0, g}, {88'd0, E_BR});

        for (int i = 0; i < 11; i++) begin
            step($sformatf("tbl%0d", i), tbl[i].rs1, tbl[i].rs2, tbl[i].rd,
                 tbl[i].ld, tbl[i].pc, tbl[i].req, tbl[i].rdy, g);
            check($sformatf("tbl%0d_exp", i), {88'd0, g}, {88'd0, tbl[i].exp});
        end

        // Reset in the middle of a memory wait.
        step("rm_entry", 0, 0, 0, 0, 0, 1, 0, g);
        step("rm_w1", 0, 0, 0, 0, 0, 1, 0, g);
        async_reset("rm");
        step("rm_init", 0, 0, 0, 0, 0, 1, 0, g);
        check("rm_init_exp", {88'd0, g}, {88'd0, E_INIT});

        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 199) == 0) begin
                async_reset($sformatf("rnd_rst%0d", i));
            end else begin
                step($sformatf("rnd%0d", i),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0),
                     1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)), g);
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
